// File: rtl/fht_ctrl_if.sv
// Start/done handshake and RAM/ROM addressing bundle between the system,
// the FHT sequencing controller and the butterfly datapath memories.
interface fht_ctrl_if #(
  parameter int A_BIT = 8,
  parameter int S_BIT = 3
);

  logic             iSTART;
  logic             oRD_BANK;
  logic [A_BIT-1:0] oRD_ADDR_1;
  logic [A_BIT-1:0] oRD_ADDR_2;
  logic [A_BIT-1:0] oRD_ADDR_0;
  logic [A_BIT-2:0] oROM_ADDR;
  logic             oWR_EN;
  logic             oWR_BANK;
  logic [A_BIT-1:0] oWR_ADDR_0;
  logic [A_BIT-1:0] oWR_ADDR_1;
  logic [S_BIT-1:0] oSTAGE;
  logic             oBUSY;
  logic             oDONE;

  // System side: requests a transform and observes the controller.
  modport master (
    output iSTART,
    input  oRD_BANK, oRD_ADDR_1, oRD_ADDR_2, oRD_ADDR_0, oROM_ADDR,
    input  oWR_EN, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1,
    input  oSTAGE, oBUSY, oDONE
  );

  // Controller side.
  modport slave (
    input  iSTART,
    output oRD_BANK, oRD_ADDR_1, oRD_ADDR_2, oRD_ADDR_0, oROM_ADDR,
    output oWR_EN, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1,
    output oSTAGE, oBUSY, oDONE
  );

endinterface

// File: rtl/fht_ctrl.sv
// Sequencing controller for the radix-2 FHT butterfly. Walks every stage and
// butterfly of an N = 2^A_BIT point transform, issuing ping-pong RAM read
// addresses and twiddle indices, then replays the butterfly's X_0/X_1
// addresses three cycles later as write addresses to match the datapath skew
// (registered multipliers, then the registered sum/difference).
module fht_ctrl #(
  parameter int A_BIT = 8,
  parameter int S_BIT = 3
) (
  input  logic      iCLK,
  input  logic      iRESET,
  fht_ctrl_if.slave bus
);

  // Last butterfly index N/2-1 is all ones; last stage is A_BIT-1.
  localparam logic [A_BIT-2:0] J_LAST  = '1;
  localparam logic [S_BIT-1:0] S_LAST  = S_BIT'(A_BIT - 1);
  localparam logic [S_BIT:0]   ROM_TOP = (S_BIT + 1)'(A_BIT - 1);
  localparam logic [1:0]       DRAIN_LAST = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [S_BIT-1:0] s_q, s_d;
  logic [A_BIT-2:0] j_q, j_d;
  logic [1:0]       drain_q, drain_d;
  logic             issue_d;
  logic             done_d;

  // Address arithmetic for the butterfly about to be issued (s_d, j_d).
  logic [A_BIT-1:0] jExt;
  logic [A_BIT-1:0] hVal;
  logic [A_BIT-1:0] kVal;
  logic [A_BIT-1:0] bVal;
  logic [A_BIT-1:0] x0_d;
  logic [A_BIT-1:0] x1_d;
  logic [A_BIT-1:0] x2_d;
  logic [S_BIT:0]   romShift;
  logic [A_BIT-2:0] rom_d;

  // Read-side output registers.
  logic [A_BIT-1:0] rdAddr1_q;
  logic [A_BIT-1:0] rdAddr2_q;
  logic [A_BIT-1:0] rdAddr0_q;
  logic [A_BIT-2:0] romAddr_q;

  // Three-deep skew pipeline carrying X_0/X_1 and the write bank.
  logic             p1Valid_q, p2Valid_q, p3Valid_q;
  logic [A_BIT-1:0] p1X0_q, p2X0_q, p3X0_q;
  logic [A_BIT-1:0] p1X1_q, p2X1_q, p3X1_q;
  logic             p1Bank_q, p2Bank_q, p3Bank_q;

  // Write-side output registers.
  logic             wrEn_q;
  logic             wrBank_q;
  logic [A_BIT-1:0] wrAddr0_q;
  logic [A_BIT-1:0] wrAddr1_q;

  logic             busy_q;
  logic             done_q;

  // b is j with the low s bits cleared, doubled; k is the low s bits of j.
  // The twiddle index spreads k across the half-length ROM so k=0 maps to
  // entry 0 (cos = 1, sin = 0) in every stage.
  assign jExt     = {1'b0, j_d};
  assign hVal     = {{(A_BIT-1){1'b0}}, 1'b1} << s_d;
  assign kVal     = jExt & (hVal - 1'b1);
  assign bVal     = ((jExt >> s_d) << s_d) << 1;
  assign x0_d     = bVal + kVal;
  assign x1_d     = bVal + hVal + kVal;
  assign x2_d     = (kVal == '0) ? (bVal + hVal) : (bVal + (hVal << 1) - kVal);
  assign romShift = ROM_TOP - {1'b0, s_d};
  assign rom_d    = kVal[A_BIT-2:0] << romShift;

  // Next-state logic: RUN issues one butterfly per cycle, DRAIN waits three
  // cycles so the last write of a stage lands before the next stage reads.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    drain_d = drain_q;
    issue_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iSTART) begin
          state_d = RUN;
          s_d     = '0;
          j_d     = '0;
          issue_d = 1'b1;
        end
      end
      RUN: begin
        if (j_q == J_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          j_d     = j_q + 1'b1;
          issue_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (s_q == S_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            s_d     = s_q + 1'b1;
            j_d     = '0;
            issue_d = 1'b1;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state, busy flag and the one-cycle done pulse.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= IDLE;
      s_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      drain_q <= drain_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  // X_1/X_2 read addresses and twiddle index; held while not issuing.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      rdAddr1_q <= '0;
      rdAddr2_q <= '0;
      romAddr_q <= '0;
    end else if (issue_d) begin
      rdAddr1_q <= x1_d;
      rdAddr2_q <= x2_d;
      romAddr_q <= rom_d;
    end
  end

  // Skew pipeline; reset clears the valids so in-flight writes are dropped.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      p1Valid_q <= 1'b0;
      p2Valid_q <= 1'b0;
      p3Valid_q <= 1'b0;
      p1X0_q    <= '0;
      p2X0_q    <= '0;
      p3X0_q    <= '0;
      p1X1_q    <= '0;
      p2X1_q    <= '0;
      p3X1_q    <= '0;
      p1Bank_q  <= 1'b0;
      p2Bank_q  <= 1'b0;
      p3Bank_q  <= 1'b0;
    end else begin
      p1Valid_q <= issue_d;
      p2Valid_q <= p1Valid_q;
      p3Valid_q <= p2Valid_q;
      p1X0_q    <= x0_d;
      p2X0_q    <= p1X0_q;
      p3X0_q    <= p2X0_q;
      p1X1_q    <= x1_d;
      p2X1_q    <= p1X1_q;
      p3X1_q    <= p2X1_q;
      p1Bank_q  <= ~s_d[0];
      p2Bank_q  <= p1Bank_q;
      p3Bank_q  <= p2Bank_q;
    end
  end

  // X_0 read one cycle behind X_1/X_2, writes three cycles behind.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      rdAddr0_q <= '0;
      wrEn_q    <= 1'b0;
      wrBank_q  <= 1'b0;
      wrAddr0_q <= '0;
      wrAddr1_q <= '0;
    end else begin
      if (p1Valid_q) begin
        rdAddr0_q <= p1X0_q;
      end
      wrEn_q <= p3Valid_q;
      if (p3Valid_q) begin
        wrBank_q  <= p3Bank_q;
        wrAddr0_q <= p3X0_q;
        wrAddr1_q <= p3X1_q;
      end
    end
  end

  assign bus.oRD_BANK   = s_q[0];
  assign bus.oRD_ADDR_1 = rdAddr1_q;
  assign bus.oRD_ADDR_2 = rdAddr2_q;
  assign bus.oRD_ADDR_0 = rdAddr0_q;
  assign bus.oROM_ADDR  = romAddr_q;
  assign bus.oWR_EN     = wrEn_q;
  assign bus.oWR_BANK   = wrBank_q;
  assign bus.oWR_ADDR_0 = wrAddr0_q;
  assign bus.oWR_ADDR_1 = wrAddr1_q;
  assign bus.oSTAGE     = s_q;
  assign bus.oBUSY      = busy_q;
  assign bus.oDONE      = done_q;

endmodule

// File: tb/tb_fht_ctrl.sv
// Self-checking bench for fht_ctrl at A_BIT = 3 (N = 8, 7 cycles per stage).
// Read-side addresses come from a table of expected butterflies; write-side
// results are checked by a scoreboard filled when a start is driven.
module tb_fht_ctrl;

  localparam int A_BIT   = 3;
  localparam int S_BIT   = 2;
  localparam int NUM_VEC = 12;
  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic rstN;

  fht_ctrl_if #(.A_BIT(A_BIT), .S_BIT(S_BIT)) bus ();

  fht_ctrl #(.A_BIT(A_BIT), .S_BIT(S_BIT)) dut (
    .iCLK   (clk),
    .iRESET (rstN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int x0;
    int x1;
    int x2;
    int rom;
    int stage;
  } issue_t;

  typedef struct {
    int wrCycle;
    int addr0;
    int addr1;
    int bank;
  } wr_t;

  issue_t vecs [NUM_VEC];
  wr_t    sbQ [$];
  wr_t    expWr;

  int checks    = 0;
  int passes    = 0;
  int edgeCount = 0;
  int startEdge = 0;
  int wrSeen    = 0;
  int wrBefore  = 0;
  int base      = 0;

  // Free-running rising-edge counter; cycle k of a run starts at edge start+k.
  always @(posedge clk) edgeCount <= edgeCount + 1;

  function automatic logic [31:0] allOut();
    return {8'b0, bus.oRD_BANK, bus.oRD_ADDR_1, bus.oRD_ADDR_2, bus.oRD_ADDR_0,
            bus.oROM_ADDR, bus.oWR_EN, bus.oWR_BANK, bus.oWR_ADDR_0,
            bus.oWR_ADDR_1, bus.oSTAGE, bus.oBUSY, bus.oDONE};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
               name, actual, actual, expected, expected, edgeCount);
    end
  endtask

  task automatic goToEdge(input int target);
    int guard = 0;
    while (edgeCount < target && guard < TIMEOUT) begin
      @(negedge clk);
      guard++;
    end
    if (edgeCount < target) begin
      checks++;
      $display("[TB] FAIL wait_timeout: reached edge %0d, expected edge %0d",
               edgeCount, target);
    end
  endtask

  task automatic pushExpected(input int runBase);
    wr_t w;
    for (int i = 0; i < NUM_VEC; i++) begin
      w.wrCycle = runBase + vecs[i].cyc + 3;
      w.addr0   = vecs[i].x0;
      w.addr1   = vecs[i].x1;
      w.bank    = 1 - (vecs[i].stage & 1);
      sbQ.push_back(w);
    end
  endtask

  // Called at a falling edge: the start is sampled at the next rising edge.
  task automatic applyStimulus(input bit hold);
    bus.iSTART = 1'b1;
    startEdge  = edgeCount;
    pushExpected(startEdge);
    if (!hold) begin
      @(negedge clk);
      bus.iSTART = 1'b0;
    end
  endtask

  task automatic checkRun(input int runBase);
    for (int i = 0; i < NUM_VEC; i++) begin
      goToEdge(runBase + vecs[i].cyc);
      checkOutput($sformatf("rd_addr_1[%0d]", i), bus.oRD_ADDR_1, vecs[i].x1);
      checkOutput($sformatf("rd_addr_2[%0d]", i), bus.oRD_ADDR_2, vecs[i].x2);
      checkOutput($sformatf("rom_addr[%0d]", i),  bus.oROM_ADDR,  vecs[i].rom);
      checkOutput($sformatf("stage[%0d]", i),     bus.oSTAGE,     vecs[i].stage);
      checkOutput($sformatf("rd_bank[%0d]", i),   bus.oRD_BANK,   vecs[i].stage & 1);
      checkOutput($sformatf("busy[%0d]", i),      bus.oBUSY,      1);
      goToEdge(runBase + vecs[i].cyc + 1);
      checkOutput($sformatf("rd_addr_0[%0d]", i), bus.oRD_ADDR_0, vecs[i].x0);
    end
    goToEdge(runBase + 21);
    checkOutput("busy_last", bus.oBUSY, 1);
    checkOutput("done_early", bus.oDONE, 0);
    goToEdge(runBase + 22);
    checkOutput("busy_at_done", bus.oBUSY, 0);
    checkOutput("done_pulse", bus.oDONE, 1);
    checkOutput("rd_addr_1_hold", bus.oRD_ADDR_1, 7);
    checkOutput("rd_addr_2_hold", bus.oRD_ADDR_2, 5);
    checkOutput("rom_addr_hold", bus.oROM_ADDR, 3);
    checkOutput("sb_empty", sbQ.size(), 0);
  endtask

  // Write-side scoreboard: every write must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.oWR_EN === 1'b1) begin
      wrSeen++;
      if (sbQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_write: got write %0d/%0d at edge %0d, expected none",
                 bus.oWR_ADDR_0, bus.oWR_ADDR_1, edgeCount);
      end else begin
        expWr = sbQ.pop_front();
        checkOutput("wr_cycle",  edgeCount,      expWr.wrCycle);
        checkOutput("wr_addr_0", bus.oWR_ADDR_0, expWr.addr0);
        checkOutput("wr_addr_1", bus.oWR_ADDR_1, expWr.addr1);
        checkOutput("wr_bank",   bus.oWR_BANK,   expWr.bank);
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1,  0, 1, 1, 0, 0};
    vecs[1]  = '{2,  2, 3, 3, 0, 0};
    vecs[2]  = '{3,  4, 5, 5, 0, 0};
    vecs[3]  = '{4,  6, 7, 7, 0, 0};
    vecs[4]  = '{8,  0, 2, 2, 0, 1};
    vecs[5]  = '{9,  1, 3, 3, 2, 1};
    vecs[6]  = '{10, 4, 6, 6, 0, 1};
    vecs[7]  = '{11, 5, 7, 7, 2, 1};
    vecs[8]  = '{15, 0, 4, 4, 0, 2};
    vecs[9]  = '{16, 1, 5, 7, 1, 2};
    vecs[10] = '{17, 2, 6, 6, 2, 2};
    vecs[11] = '{18, 3, 7, 5, 3, 2};

    bus.iSTART = 1'b0;
    rstN = 1'b1;
    #1 rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOut(), 0);
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_outputs", allOut(), 0);
    end

    $display("[TB] single transform");
    applyStimulus(1'b0);
    checkRun(startEdge);
    goToEdge(startEdge + 23);
    checkOutput("done_single_pulse", bus.oDONE, 0);
    checkOutput("idle_busy", bus.oBUSY, 0);

    $display("[TB] reset in the middle of stage 1");
    repeat (2) @(negedge clk);
    applyStimulus(1'b0);
    goToEdge(startEdge + 10);
    checkOutput("pre_reset_rd_addr_1", bus.oRD_ADDR_1, 6);
    rstN = 1'b0;
    #1;
    checkOutput("midrun_reset_outputs", allOut(), 0);
    sbQ.delete();
    wrBefore = wrSeen;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("writes_after_reset", wrSeen, wrBefore);
    checkOutput("post_reset_outputs", allOut(), 0);

    $display("[TB] full transform after reset");
    applyStimulus(1'b0);
    checkRun(startEdge);

    $display("[TB] start held high across two transforms");
    repeat (2) @(negedge clk);
    applyStimulus(1'b1);
    base = startEdge;
    checkRun(base);
    pushExpected(base + 22);
    checkRun(base + 22);
    bus.iSTART = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("held_final_busy", bus.oBUSY, 0);
    checkOutput("held_final_sb_empty", sbQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fht_ctrl.md
# fht_ctrl

Sequencing controller for the radix-2 FHT butterfly datapath. It walks all stages and butterflies of an N = 2^A_BIT point transform and issues ping-pong RAM read addresses, twiddle ROM addresses and delayed write addresses. Its timing matches the butterfly's internal skew: multipliers are registered one cycle before the X_0 add, and the sum/difference is registered on top of that. It sits upstream of the butterfly, between the data RAM banks and the twiddle ROM, and owns the start/done handshake with the system.

## Interface
- A_BIT, default 8: log2 of transform length N; also the number of stages.
- S_BIT, default 3: stage counter width, ceil(log2(A_BIT)).
- iCLK in 1: clock; all state changes on rising edge.
- iRESET in 1: asynchronous, active-low reset.
- iSTART in 1: start request, sampled on rising edge, ignored while busy.
- oRD_BANK out 1: RAM bank read this stage; the other bank is written.
- oRD_ADDR_1 out A_BIT: read address feeding butterfly X_1 (cos term).
- oRD_ADDR_2 out A_BIT: read address feeding butterfly X_2 (sin term).
- oRD_ADDR_0 out A_BIT: read address feeding X_0, issued one cycle after ADDR_1/2.
- oROM_ADDR out A_BIT-1: twiddle index, aligned with oRD_ADDR_1/2.
- oWR_EN out 1: write strobe for butterfly outputs.
- oWR_BANK out 1: bank written, aligned with oWR_EN.
- oWR_ADDR_0 out A_BIT: destination of oY_0.
- oWR_ADDR_1 out A_BIT: destination of oY_1.
- oSTAGE out S_BIT: current stage index s.
- oBUSY out 1: high while a transform is in progress.
- oDONE out 1: one-cycle pulse when the final write has completed.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on iSTART; s = 0, j = 0.
  - RUN issues one butterfly per cycle, j = 0 … N/2−1; after j = N/2−1 → DRAIN.
  - DRAIN lasts exactly 3 cycles. It then goes → RUN with s+1, j = 0, or → IDLE with oDONE if s = A_BIT−1.
- Address math for stage s, with H = 2^s and L = 2H:
  - g = j >> s; k = j & (H−1); b = g·L.
  - X_0 = b+k; X_1 = b+H+k.
  - X_2 = b+H when k = 0, otherwise b+L−k.
  - twiddle index = k << (A_BIT−1−s); index 0 must yield cos = 1.0, sin = 0.
- Write addresses are oWR_ADDR_0 = X_0 and oWR_ADDR_1 = X_1 of the same butterfly.
- Banks: oRD_BANK = s[0]; oWR_BANK = ~s[0].
  - Input data lives in bank 0.
  - The result lands in bank (A_BIT mod 2).
- Address arithmetic is unsigned and modulo 2^A_BIT; no computed value exceeds N−1.
- iSTART while busy has no effect. iSTART in the oDONE cycle starts a new transform.
- Reset at any point, including mid-stage or during DRAIN:
  - returns to IDLE and cancels the in-flight pipeline, so no further oWR_EN;
  - all outputs go to 0.

## Timing
- Reset values: every output is 0, including oRD_BANK, oWR_BANK, oSTAGE, oBUSY and oDONE.
- RAM and ROM read latency is fixed at 1 cycle.
- For a butterfly whose oRD_ADDR_1/2 and oROM_ADDR are valid in cycle c:
  - oRD_ADDR_0 is valid in c+1;
  - oWR_EN, oWR_ADDR_0/1 and oWR_BANK are valid in c+3.
- All outputs are registered.
- Address outputs hold their last value when not issuing.
- Timeline from iSTART high in cycle 0:
  - stage s issues in cycles 1+s·(N/2+3) … s·(N/2+3)+N/2;
  - oBUSY is high in cycles 1 … A_BIT·(N/2+3);
  - oDONE pulses in cycle A_BIT·(N/2+3)+1, with oBUSY low.
- The DRAIN of 3 cycles guarantees the last write of stage s (cycle c+3) precedes the first read of stage s+1 (cycle c+4).
- oSTAGE changes in the first RUN cycle of the new stage.

## Test plan
- Reset: hold iRESET low, then release with no iSTART → all outputs 0 indefinitely, state IDLE.
- A_BIT=3, iSTART in cycle 0:
  - stage 1 issues (X_0, X_1, X_2, rom) = (0,2,2,0), (1,3,3,2), (4,6,6,0), (5,7,7,2) in cycles 8–11;
  - oRD_BANK = 1 and oWR_BANK = 0.
- A_BIT=3, stage 2 (cycles 15–18): (0,4,4,0), (1,5,7,1), (2,6,6,2), (3,7,5,3).
- A_BIT=3 alignment:
  - oRD_ADDR_0 trails oRD_ADDR_1 by exactly 1 cycle;
  - oWR_EN pulses in cycles 4–7, 11–14 and 18–21;
  - oDONE is a single pulse in cycle 22; oBUSY is high in cycles 1–21.
- Reset asserted in cycle 10 of an A_BIT=3 run → outputs 0 immediately, no oWR_EN afterwards. A new iSTART after release repeats the full sequence from stage 0.
- iSTART held high continuously, A_BIT=3 → extra requests ignored while busy. The next transform's first read occurs in cycle 23; oDONE pulses every 22 cycles.
